// File: rtl/writeback_stage_if.sv
// writeback_stage_if: MEM->WB pipeline bus, stall/flush control, bypass lookup and register-file write port
// master: drives mem_*, stall, flush, ex_rs/ex_rt; reads the write port, bypass results and retire_count
// slave: the writeback stage itself
interface writeback_stage_if;
  logic        mem_valid, mem_RegWrite, mem_MemtoReg;
  logic [4:0]  mem_rd;
  logic [31:0] mem_aluResult, mem_readData;
  logic        stall, flush;
  logic [4:0]  ex_rs, ex_rt;
  logic [4:0]  rd;
  logic [31:0] writeData;
  logic        RegWrite;
  logic        fwdA_hit, fwdB_hit;
  logic [31:0] fwdA_data, fwdB_data;
  logic [31:0] retire_count;
  modport master (
    output mem_valid, mem_RegWrite, mem_MemtoReg, mem_rd, mem_aluResult, mem_readData,
    output stall, flush, ex_rs, ex_rt,
    input  rd, writeData, RegWrite, fwdA_hit, fwdB_hit, fwdA_data, fwdB_data, retire_count
  );
  modport slave (
    input  mem_valid, mem_RegWrite, mem_MemtoReg, mem_rd, mem_aluResult, mem_readData,
    input  stall, flush, ex_rs, ex_rt,
    output rd, writeData, RegWrite, fwdA_hit, fwdB_hit, fwdA_data, fwdB_data, retire_count
  );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: WB pipeline register, register-file write port, two-deep bypass and optional retire counter
// ports: clk, reset (async, active-high), b (writeback_stage_if.slave: mem_* in, stall/flush, ex_rs/ex_rt,
//        rd/writeData/RegWrite write port, fwdA/fwdB bypass, retire_count)
// WB_RETIRE_COUNT_EN: builds the 32-bit retired-instruction counter; otherwise retire_count is 0
module writeback_stage (
  input logic clk,
  input logic reset,
  writeback_stage_if.slave b
);
  logic        wb_valid, wb_regwrite, wb_memtoreg;
  logic [4:0]  wb_rd;
  logic [31:0] wb_alu, wb_rdata;
  logic        prev_valid;
  logic [4:0]  prev_rd;
  logic [31:0] prev_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_memtoreg <= 1'b0;
      wb_rd       <= '0;
      wb_alu      <= '0;
      wb_rdata    <= '0;
      prev_valid  <= 1'b0;
      prev_rd     <= '0;
      prev_data   <= '0;
    end else begin
      if (b.flush) wb_valid <= 1'b0;
      else if (!b.stall) begin
        wb_valid    <= b.mem_valid;
        wb_regwrite <= b.mem_RegWrite;
        wb_memtoreg <= b.mem_MemtoReg;
        wb_rd       <= b.mem_rd;
        wb_alu      <= b.mem_aluResult;
        wb_rdata    <= b.mem_readData;
      end
      // last cycle's write stays visible while the register file's registered read catches up
      prev_valid <= b.RegWrite;
      prev_rd    <= b.rd;
      prev_data  <= b.writeData;
    end
  assign b.RegWrite  = wb_valid & wb_regwrite & (wb_rd != 5'd0);
  assign b.rd        = wb_rd;
  assign b.writeData = wb_memtoreg ? wb_rdata : wb_alu;
  logic a_cur, a_prev, b_cur, b_prev;
  always_comb begin
    a_cur  = b.RegWrite & (b.rd == b.ex_rs);
    a_prev = prev_valid & (prev_rd == b.ex_rs);
    b_cur  = b.RegWrite & (b.rd == b.ex_rt);
    b_prev = prev_valid & (prev_rd == b.ex_rt);
    b.fwdA_hit  = (b.ex_rs != 5'd0) & (a_cur | a_prev);
    b.fwdB_hit  = (b.ex_rt != 5'd0) & (b_cur | b_prev);
    b.fwdA_data = !b.fwdA_hit ? 32'd0 : a_cur ? b.writeData : prev_data;
    b.fwdB_data = !b.fwdB_hit ? 32'd0 : b_cur ? b.writeData : prev_data;
  end
`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (wb_valid && !b.stall) cnt <= cnt + 32'd1;
  assign b.retire_count = cnt;
`else
  assign b.retire_count = 32'd0;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed vectors with literal expectations plus a per-cycle behavioural model check
module tb_writeback_stage;
  logic clk = 0, reset = 1;
  writeback_stage_if bus ();
  writeback_stage dut (.clk(clk), .reset(reset), .b(bus));
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  typedef struct packed {logic v, we, m2r; logic [4:0] rd; logic [31:0] alu, rdat;} ins_t;
  typedef struct packed {logic v; logic [4:0] rd; logic [31:0] d;} wr_t;
  ins_t m_cur;
  wr_t m_hist;
  logic [31:0] m_cnt;
  function automatic wr_t port(input ins_t c);
    wr_t w;
    w.v  = c.v & c.we & (c.rd != 0);
    w.rd = c.rd;
    w.d  = c.m2r ? c.rdat : c.alu;
    return w;
  endfunction
  function automatic logic [32:0] byp(input logic [4:0] r);
    wr_t w;
    w = port(m_cur);
    if (r == 0) return 33'd0;
    if (w.v && w.rd == r) return {1'b1, w.d};
    if (m_hist.v && m_hist.rd == r) return {1'b1, m_hist.d};
    return 33'd0;
  endfunction
  always @(posedge clk or posedge reset)
    if (reset) begin
      m_cur  <= '0;
      m_hist <= '0;
      m_cnt  <= 0;
    end else begin
      m_hist <= port(m_cur);
`ifdef WB_RETIRE_COUNT_EN
      if (m_cur.v && !bus.stall) m_cnt <= m_cnt + 1;
`endif
      if (bus.flush) m_cur.v <= 1'b0;
      else if (!bus.stall)
        m_cur <= '{bus.mem_valid, bus.mem_RegWrite, bus.mem_MemtoReg, bus.mem_rd, bus.mem_aluResult, bus.mem_readData};
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    wr_t w;
    logic [32:0] fa, fb;
    w  = port(m_cur);
    fa = byp(bus.ex_rs);
    fb = byp(bus.ex_rt);
    chk("m_RegWrite", {31'd0, bus.RegWrite}, {31'd0, w.v});
    chk("m_rd", {27'd0, bus.rd}, {27'd0, w.rd});
    chk("m_writeData", bus.writeData, w.d);
    chk("m_fwdA_hit", {31'd0, bus.fwdA_hit}, {31'd0, fa[32]});
    chk("m_fwdA_data", bus.fwdA_data, fa[31:0]);
    chk("m_fwdB_hit", {31'd0, bus.fwdB_hit}, {31'd0, fb[32]});
    chk("m_fwdB_data", bus.fwdB_data, fb[31:0]);
    chk("m_retire_count", bus.retire_count, m_cnt);
  end
  task automatic drive(input logic v, we, m2r, input logic [4:0] rd, input logic [31:0] alu, rdat);
    bus.mem_valid = v;
    bus.mem_RegWrite = we;
    bus.mem_MemtoReg = m2r;
    bus.mem_rd = rd;
    bus.mem_aluResult = alu;
    bus.mem_readData = rdat;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(1, 1, 0, 5'd6, 32'h77, 32'h0);
    bus.stall = 1;
    bus.flush = 1;
    bus.ex_rs = 6;
    bus.ex_rt = 6;
    tick;
    tick;
    chk("rst_RegWrite", {31'd0, bus.RegWrite}, 0);
    chk("rst_writeData", bus.writeData, 0);
    chk("rst_fwdA_hit", {31'd0, bus.fwdA_hit}, 0);
    chk("rst_retire", bus.retire_count, 0);
    reset = 0;
    bus.stall = 0;
    bus.flush = 0;
    bus.ex_rs = 0;
    bus.ex_rt = 0;
    drive(1, 1, 0, 5'd5, 32'hAA, 32'h0);
    tick;
    chk("alu_RegWrite", {31'd0, bus.RegWrite}, 1);
    chk("alu_rd", {27'd0, bus.rd}, 5);
    chk("alu_writeData", bus.writeData, 32'hAA);
    drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
    bus.ex_rs = 5;
    tick;
    chk("idle_RegWrite", {31'd0, bus.RegWrite}, 0);
    chk("prev_fwdA_hit", {31'd0, bus.fwdA_hit}, 1);
    chk("prev_fwdA_data", bus.fwdA_data, 32'hAA);
    bus.ex_rs = 0;
    drive(1, 1, 1, 5'd9, 32'hDEADBEEF, 32'h12345678);
    tick;
    chk("load_writeData", bus.writeData, 32'h12345678);
    chk("load_RegWrite", {31'd0, bus.RegWrite}, 1);
    drive(1, 1, 1, 5'd0, 32'hDEADBEEF, 32'h12345678);
    tick;
    chk("r0_RegWrite", {31'd0, bus.RegWrite}, 0);
    bus.ex_rs = 3;
    drive(1, 1, 0, 5'd3, 32'h11, 32'h0);
    tick;
    chk("b2b1_fwdA_data", bus.fwdA_data, 32'h11);
    drive(1, 1, 0, 5'd3, 32'h22, 32'h0);
    tick;
    chk("b2b2_fwdA_data", bus.fwdA_data, 32'h22);
    drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
    tick;
    chk("b2b_prev_hit", {31'd0, bus.fwdA_hit}, 1);
    chk("b2b_prev_data", bus.fwdA_data, 32'h22);
    tick;
    chk("b2b_gone_hit", {31'd0, bus.fwdA_hit}, 0);
    bus.ex_rs = 0;
    bus.ex_rt = 7;
    drive(1, 1, 0, 5'd7, 32'h55, 32'h0);
    tick;
    bus.stall = 1;
    drive(1, 1, 0, 5'd8, 32'h99, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_RegWrite", {31'd0, bus.RegWrite}, 1);
      chk("stall_rd", {27'd0, bus.rd}, 7);
      chk("stall_writeData", bus.writeData, 32'h55);
      chk("stall_fwdB_data", bus.fwdB_data, 32'h55);
    end
    bus.flush = 1;
    tick;
    chk("flush_RegWrite", {31'd0, bus.RegWrite}, 0);
    bus.stall = 0;
    bus.flush = 0;
    bus.ex_rs = 0;
    bus.ex_rt = 4;
    drive(1, 1, 0, 5'd0, 32'h33, 32'h0);
    tick;
    chk("rs0_r0_hit", {31'd0, bus.fwdA_hit}, 0);
    chk("rs0_r0_data", bus.fwdA_data, 0);
    drive(1, 1, 0, 5'd4, 32'h44, 32'h0);
    tick;
    chk("rs0_r4_hit", {31'd0, bus.fwdA_hit}, 0);
    chk("rs0_r4_data", bus.fwdA_data, 0);
    chk("rt4_data", bus.fwdB_data, 32'h44);
    for (int i = 0; i < 24; i++) begin
      bus.stall = (i % 5) == 3;
      bus.flush = (i % 7) == 6;
      bus.ex_rs = 5'(i % 4);
      bus.ex_rt = 5'((i + 1) % 4);
      drive(1'((i % 6) != 2), 1'((i % 3) != 1), 1'(i % 2), 5'(i % 4), 32'(i * 32'h1111), 32'(i * 32'h0101_0000));
      tick;
    end
    bus.stall = 0;
    bus.flush = 0;
    drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
    reset = 1;
    tick;
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 5'(i + 1), 32'(i + 16), 32'h0);
      tick;
    end
    bus.stall = 1;
    tick;
    drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
    bus.stall = 0;
    tick;
`ifdef WB_RETIRE_COUNT_EN
    chk("retire_4", bus.retire_count, 4);
`else
    chk("retire_off", bus.retire_count, 0);
`endif
    drive(1, 1, 0, 5'd2, 32'hBB, 32'h0);
    tick;
    #1 reset = 1;
    #1;
    chk("async_RegWrite", {31'd0, bus.RegWrite}, 0);
    chk("async_retire", bus.retire_count, 0);
    chk("async_writeData", bus.writeData, 0);
    reset = 0;
    drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
    tick;
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
